// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scanner.
//   scan_state_e : scanner FSM states
//   SEG_OFF      : all segments dark (active-low)
//   hex_to_seg() : 4-bit nibble to active-low {g,f,e,d,c,b,a} pattern
package seg7_pkg;

  typedef enum logic [1:0] {
    StWait,
    StBlank,
    StShow
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex-to-seven-segment decoder.
//   nibble  : 4-bit hex digit
//   pattern : active-low segments {g,f,e,d,c,b,a}
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner with blanking gap,
// per-digit decimal points and optional leading-zero suppression.
//   clk, rst : clock, asynchronous active-low reset
//   tick     : divider square wave; each rising edge advances one digit
//   value    : 16-bit hex value, digit 0 rightmost
//   dp       : per-digit decimal point enable (active-high)
//   lz_en    : leading-zero suppression enable
//   an       : digit enables, active-low
//   seg      : segments {g,f,e,d,c,b,a}, active-low
//   seg_dp   : decimal point segment, active-low
//   frame    : one-cycle pulse when digit 0 is selected and a snapshot taken
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        seg_dp,
  output logic        frame
);

  localparam logic [3:0] BlankLoad = 4'(BLANK_CYCLES - 1);

  scan_state_e state;
  logic        tick_d;
  logic        armed;
  logic        strobe;
  logic [1:0]  idx;
  logic [1:0]  idx_nxt;
  logic [3:0]  blank_cnt;
  logic        suppress;

  logic [15:0] value_snap;
  logic [3:0]  dp_snap;
  logic        lz_snap;

  logic        take_snap;
  logic [15:0] src_value;
  logic [3:0]  src_dp;
  logic        src_lz;
  logic [3:0]  nibble;
  logic [6:0]  pattern;
  logic        suppress_nxt;

  // armed stays low for the first cycle after reset so that a tick already
  // high at release is only sampled into tick_d, never seen as an edge.
  always_comb begin
    strobe    = tick & ~tick_d & armed;
    idx_nxt   = idx + 2'd1;
    take_snap = strobe && (idx_nxt == 2'd0);
    // Digit 0 must show the data being latched on this same edge.
    src_value = take_snap ? value : value_snap;
    src_dp    = take_snap ? dp    : dp_snap;
    src_lz    = take_snap ? lz_en : lz_snap;

    nibble       = src_value[3:0];
    suppress_nxt = 1'b0;
    case (idx_nxt)
      2'd0: nibble = src_value[3:0];
      2'd1: begin
        nibble       = src_value[7:4];
        suppress_nxt = src_lz && (src_value[15:4] == 12'h000);
      end
      2'd2: begin
        nibble       = src_value[11:8];
        suppress_nxt = src_lz && (src_value[15:8] == 8'h00);
      end
      default: begin
        nibble       = src_value[15:12];
        suppress_nxt = src_lz && (src_value[15:12] == 4'h0);
      end
    endcase
  end

  seg7_hex_dec u_hex_dec (
    .nibble  (nibble),
    .pattern (pattern)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StWait;
      tick_d     <= 1'b0;
      armed      <= 1'b0;
      idx        <= 2'd3;
      blank_cnt  <= 4'd0;
      suppress   <= 1'b0;
      value_snap <= 16'h0000;
      dp_snap    <= 4'h0;
      lz_snap    <= 1'b0;
      an         <= 4'hF;
      seg        <= SEG_OFF;
      seg_dp     <= 1'b1;
      frame      <= 1'b0;
    end else begin
      tick_d <= tick;
      armed  <= 1'b1;
      frame  <= 1'b0;
      if (strobe) begin
        idx       <= idx_nxt;
        an        <= 4'hF;
        blank_cnt <= BlankLoad;
        state     <= StBlank;
        suppress  <= suppress_nxt;
        seg       <= suppress_nxt ? SEG_OFF : pattern;
        seg_dp    <= suppress_nxt | ~src_dp[idx_nxt];
        if (take_snap) begin
          value_snap <= value;
          dp_snap    <= dp;
          lz_snap    <= lz_en;
          frame      <= 1'b1;
        end
      end else begin
        case (state)
          StBlank: begin
            if (blank_cnt == 4'd0) begin
              state <= StShow;
              if (!suppress) an <= ~(4'b0001 << idx);
            end else begin
              blank_cnt <= blank_cnt - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

  localparam int unsigned BlankCycles = 2;
  localparam int unsigned TickHalf    = 4;

  typedef struct packed {
    logic [3:0] an_lit;
    logic [6:0] seg;
    logic       seg_dp;
    logic       frame;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        tick;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        seg_dp;
  logic        frame;

  int checks;
  int failures;

  exp_t sb[$];

  // Bench-side model of the scanner's digit index and snapshot.
  logic [1:0]  m_idx;
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic        m_lz;

  seg7_scan #(
    .BLANK_CYCLES (BlankCycles)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .value  (value),
    .dp     (dp),
    .lz_en  (lz_en),
    .an     (an),
    .seg    (seg),
    .seg_dp (seg_dp),
    .frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] nib);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[nib];
  endfunction

  function automatic logic m_suppressed(input int i);
    if (i == 0 || !m_lz) return 1'b0;
    for (int j = i; j < 4; j++) begin
      if (m_value[4*j +: 4] != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_idx   = 2'd3;
    m_value = 16'h0000;
    m_dp    = 4'h0;
    m_lz    = 1'b0;
  endtask

  // Raise tick and push what the DUT must show after the advance edge.
  task automatic drive_strobe();
    exp_t e;
    logic sup;
    tick  = 1'b1;
    m_idx = m_idx + 2'd1;
    e.frame = 1'b0;
    if (m_idx == 2'd0) begin
      m_value = value;
      m_dp    = dp;
      m_lz    = lz_en;
      e.frame = 1'b1;
    end
    sup      = m_suppressed(int'(m_idx));
    e.an_lit = sup ? 4'hF : ~(4'b0001 << m_idx);
    e.seg    = sup ? 7'h7F : ref_seg(m_value[4*m_idx +: 4]);
    e.seg_dp = sup ? 1'b1 : ~m_dp[m_idx];
    sb.push_back(e);
  endtask

  // One full tick period; entered and left at a negedge of clk.
  task automatic step_digit();
    exp_t e;
    drive_strobe();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("e0_an",     16'(an),     16'hF);
    check_eq("e0_seg",    16'(seg),    16'(e.seg));
    check_eq("e0_seg_dp", 16'(seg_dp), 16'(e.seg_dp));
    check_eq("e0_frame",  16'(frame),  16'(e.frame));
    for (int k = 1; k < int'(TickHalf); k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check_eq("frame_drop", 16'(frame), 16'h0);
      if (k == int'(BlankCycles) - 1) check_eq("blank_an", 16'(an), 16'hF);
      if (k == int'(BlankCycles)) check_eq("lit_an", 16'(an), 16'(e.an_lit));
    end
    @(negedge clk);
    tick = 1'b0;
    repeat (TickHalf) @(posedge clk);
    #1;
    check_eq("hold_an",  16'(an),  16'(e.an_lit));
    check_eq("hold_seg", 16'(seg), 16'(e.seg));
    @(negedge clk);
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, "_an"},     16'(an),     16'hF);
    check_eq({tag, "_seg"},    16'(seg),    16'h7F);
    check_eq({tag, "_seg_dp"}, 16'(seg_dp), 16'h1);
    check_eq({tag, "_frame"},  16'(frame),  16'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    tick     = 1'b0;
    value    = 16'h1234;
    dp       = 4'h0;
    lz_en    = 1'b0;
    model_reset();

    // Held in reset while tick toggles: everything dark.
    repeat (4) begin
      @(negedge clk);
      tick = ~tick;
      @(posedge clk);
      #1;
      check_dark("rst_hold");
    end

    // Release with tick already high: not an edge.
    @(negedge clk);
    tick = 1'b1;
    rst  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_dark("rel_tick_high");
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_dark("rel_idle");
    @(negedge clk);

    // Basic scan, then snapshot behaviour across a mid-frame value change.
    repeat (3) step_digit();
    value = 16'hABCD;
    repeat (5) step_digit();

    // Leading-zero suppression with a decimal point on digit 1.
    lz_en = 1'b1;
    value = 16'h0030;
    dp    = 4'b0010;
    repeat (4) step_digit();
    value = 16'h0000;
    repeat (4) step_digit();

    // Light digit 2, then reset between clock edges.
    lz_en = 1'b0;
    value = 16'h1234;
    dp    = 4'h0;
    repeat (3) step_digit();
    check_eq("pre_rst_an", 16'(an), 16'hB);
    #2;
    rst = 1'b0;
    #1;
    check_dark("async_rst");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_dark("post_rst");
    @(negedge clk);
    step_digit();

    check_eq("sb_empty", 16'(sb.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Four-digit multiplexed seven-segment display scanner. It sits directly downstream of the board clock divider and consumes that divider's slow square-wave output as its scan tick. It shows a 16-bit hex value, one digit per tick, with a programmable anode blanking gap against ghosting, per-digit decimal points and optional leading-zero suppression. All logic runs in the `clk` domain; `tick` is a registered bit of a `clk`-domain divider, so no synchroniser is needed.

## Interface
- `BLANK_CYCLES`, default 2: number of `clk` cycles all anodes stay off after each digit advance. Legal range 1..15.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  divider output (square wave); each rising edge advances one digit.
- `value`  in  16  hex value to display; digit i = `value[4i+3:4i]`; digit 0 is the rightmost.
- `dp`  in  4  decimal point enable per digit, active-high.
- `lz_en`  in  1  leading-zero suppression enable.
- `an`  out  4  digit enables, active-low; `an[i]` drives digit i.
- `seg`  out  7  segments, active-low, ordered `{g,f,e,d,c,b,a}`.
- `seg_dp`  out  1  decimal point segment, active-low.
- `frame`  out  1  one-cycle pulse when digit 0 is selected and a new snapshot is taken.

## Operation
- **Edge detect.** `tick_d` registers `tick` (reset 0). `strobe = tick & ~tick_d`. Falling edges are ignored.
- **States:** WAIT (after reset), BLANK and SHOW.
- **Digit index.** `idx` is 2 bits and resets to 3, so the first strobe selects digit 0. Each strobe sets `idx <= idx+1` mod 4.
- **On strobe, from any state:**
  - all anodes go off;
  - `blank_cnt <= BLANK_CYCLES-1`;
  - state goes to BLANK;
  - `seg` and `seg_dp` load the pattern for the new `idx`.
- **Snapshot.** When the new `idx` is 0, `value`, `dp` and `lz_en` are latched into the snapshot registers and `frame` pulses. All display data comes from the snapshot, so there is no tearing within a frame.
- **BLANK.** `blank_cnt` decrements each cycle. When it reaches 0, state goes to SHOW and `an[idx]` goes low, unless the digit is suppressed.
- **SHOW.** Outputs hold until the next strobe.
- **Strobe during BLANK.** Restart the blank and advance `idx`. Only relevant when the tick period is ≤ `BLANK_CYCLES`.
- **Hex decode.** Standard 0-F patterns. Examples:
  - 0 = 1000000
  - 1 = 1111001
  - 3 = 0110000
  - 4 = 0011001
  - 8 = 0000000
  - A = 0001000
  - F = 0001110
- **Leading-zero suppression.** Digit i (i ≥ 1) is suppressed when `lz_en_snap` is set, its nibble is 0, and all higher nibbles are 0. Digit 0 is never suppressed. A suppressed digit keeps its anode off and drives `seg=7'h7F`, `seg_dp=1`.
- **Decimal point.** `seg_dp = ~dp_snap[idx]`, except for a suppressed digit.

## Timing
- **Reset values (asynchronous, immediate):**
  - `an=4'hF`, `seg=7'h7F`, `seg_dp=1`, `frame=0`;
  - state WAIT, `idx=3`;
  - snapshots 0, `tick_d=0`.
- **Registered outputs.** All outputs are registered; there is no combinational input-to-output path.
- **Advance edge E0.** Let E0 be the `clk` edge at the end of the cycle in which `strobe` is high. At E0:
  - `an` goes to 4'hF;
  - `seg`, `seg_dp` and `idx` update;
  - `frame` goes high for one cycle when `idx` becomes 0.
- **Anode enable.** `an[idx]` goes low at E0+`BLANK_CYCLES`.
- **Steady state.** A digit is lit for (tick period − `BLANK_CYCLES`) cycles, and a full frame takes 4 tick periods.
- **Reset mid-operation.** Outputs go dark with no clock edge. After release, nothing lights until the first rising edge of `tick`. A `tick` already high at release is not an edge.

## Structure
- **Package `seg7_pkg`:**
  - state enum `{WAIT, BLANK, SHOW}`;
  - constant `SEG_OFF = 7'h7F`;
  - hex-to-segment function / 16-entry table.
- **Sub-module `seg7_hex_dec`:** combinational, 4-bit nibble in, 7-bit active-low pattern out. It is instantiated once, on the snapshot nibble selected by the next `idx`.
- **Scanner:** edge detector, state machine, counters and output registers live in `seg7_scan`.

## Test plan
- **Reset.** Hold `rst=0`, toggle `tick` → `an=F`, `seg=7F`, `seg_dp=1`, `frame=0` throughout. Release `rst` with `tick` low and no edge → outputs unchanged.
- **Basic scan.** `BLANK_CYCLES=2`, `tick` period 8, `value=16'h1234`, `lz_en=0`, `dp=0`:
  - first E0: `frame=1`, `an=F`, `seg=0011001`;
  - E0+2: `an=1110`;
  - next digits in order: `an` 1101/0110000, 1011/"2", 0111/1111001.
- **Snapshot.** Change `value` to 16'hABCD while digit 2 is lit → digits 2 and 3 still show "2" and "1". After the next `frame`, digit 0 shows D.
- **Leading-zero suppression.** `lz_en=1`, `value=16'h0030` → digits 3 and 2 keep `an` high with `seg=7F`, digit 1 shows 0110000, digit 0 shows 1000000. With `value=0` only digit 0 lights, showing "0".
- **Decimal point.** `dp=4'b0010` → `seg_dp=0` only while `an=1101`. With `lz_en=1`, `value=0` and `dp=4'b0010`, `seg_dp` stays 1.
- **Reset during SHOW.** Assert `rst` low between `clk` edges while `an=1011` → `an=F` and `seg=7F` before the next edge. After release, the first tick rising edge lights digit 0 with `frame=1`.
